// File: rtl/noc_vc_buffer_if.sv
// Link bundle between an upstream flit source, the VC input buffer and the downstream consumer.
// The slave modport is the buffer's view; the master modport is the driving environment.
interface noc_vc_buffer_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [FLIT_WIDTH-1:0]  in_flit;
  logic                   in_last;
  logic [CHANNELS-1:0]    in_valid;
  logic [CHANNELS-1:0]    in_ready;
  logic [FLIT_WIDTH-1:0]  out_flit;
  logic                   out_last;
  logic                   out_valid;
  logic [CHANNELS-1:0]    out_vc;
  logic                   out_ready;
  logic [CHANNELS*CW-1:0] fill_count;

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid, out_vc, fill_count
  );

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid, out_vc, fill_count
  );
endinterface

// File: rtl/noc_vc_buffer.sv
// Per-VC FIFOs (RAM plus a head register) merged onto one output link by a
// packet-locked round-robin arbiter, so packets from different VCs never interleave.
module noc_vc_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 8
) (
  input logic             clk,
  input logic             rst_n,
  noc_vc_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = $clog2(CHANNELS);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "noc_vc_buffer: DEPTH must be a power of 2 and at least 2");
  end
  if (CHANNELS < 2) begin : g_channel_check
    $fatal(1, "noc_vc_buffer: CHANNELS must be at least 2");
  end

  logic [CHANNELS-1:0]                 head_valid;
  logic [CHANNELS-1:0]                 head_last_all;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] head_flit_all;
  logic [CHANNELS-1:0]                 wr_en;
  logic [CHANNELS-1:0]                 rd_en;

  logic [VW-1:0] grant;
  logic [VW-1:0] rr_idx;
  logic [VW:0]   rr_k;
  logic          rr_found;
  logic          out_valid_int;
  logic [VW-1:0] rr_ptr_reg;
  logic [VW-1:0] lock_vc_reg;
  logic [VW-1:0] hold_vc_reg;
  logic          lock_reg;
  logic          hold_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
      logic [FLIT_WIDTH:0]   mem [DEPTH];
      logic [AW-1:0]         wr_ptr_reg;
      logic [AW-1:0]         rd_ptr_reg;
      logic [CW-1:0]         count_reg;
      logic [FLIT_WIDTH-1:0] head_flit_reg;
      logic                  head_last_reg;
      logic                  through;
      logic                  refill;

      assign head_valid[gi]    = (count_reg != '0);
      assign head_flit_all[gi] = head_flit_reg;
      assign head_last_all[gi] = head_last_reg;
      assign bus.in_ready[gi]  = (count_reg <= CW'(DEPTH));
      assign bus.fill_count[gi*CW +: CW] = count_reg;

      assign wr_en[gi] = bus.in_valid[gi] & bus.in_ready[gi];
      assign rd_en[gi] = out_valid_int & bus.out_ready & (grant == VW'(gi));
      // An empty head, or one being drained with nothing behind it, takes the flit directly.
      assign through = (count_reg == '0) || ((count_reg == CW'(1)) && rd_en[gi]);
      assign refill  = rd_en[gi] && (count_reg > CW'(1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg  <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (wr_en[gi] && !through) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (refill)                rd_ptr_reg <= rd_ptr_reg + AW'(1);
          if (wr_en[gi] && !rd_en[gi])      count_reg <= count_reg + CW'(1);
          else if (rd_en[gi] && !wr_en[gi]) count_reg <= count_reg - CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en[gi] && !through) mem[wr_ptr_reg] <= {bus.in_last, bus.in_flit};
        if (wr_en[gi] && through)  {head_last_reg, head_flit_reg} <= {bus.in_last, bus.in_flit};
        else if (refill)           {head_last_reg, head_flit_reg} <= mem[rd_ptr_reg];
      end
    end
  endgenerate

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr_reg;
    rr_k     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rr_k = {1'b0, rr_ptr_reg} + (VW+1)'(i);
      if (rr_k >= (VW+1)'(CHANNELS)) rr_k = rr_k - (VW+1)'(CHANNELS);
      if (!rr_found && head_valid[rr_k[VW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_k[VW-1:0];
      end
    end
    if (lock_reg)      grant = lock_vc_reg;
    else if (hold_reg) grant = hold_vc_reg;
    else               grant = rr_idx;
    out_valid_int = head_valid[grant];
  end

  assign bus.out_valid = out_valid_int;
  assign bus.out_flit  = head_flit_all[grant];
  assign bus.out_last  = head_last_all[grant];
  assign bus.out_vc    = out_valid_int ? (CHANNELS'(1) << grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      lock_reg    <= 1'b0;
      lock_vc_reg <= '0;
      hold_reg    <= 1'b0;
      hold_vc_reg <= '0;
    end else if (out_valid_int) begin
      if (bus.out_ready) begin
        hold_reg <= 1'b0;
        if (bus.out_last) begin
          lock_reg   <= 1'b0;
          rr_ptr_reg <= (grant == VW'(CHANNELS - 1)) ? '0 : grant + VW'(1);
        end else begin
          lock_reg    <= 1'b1;
          lock_vc_reg <= grant;
        end
      end else begin
        // A stalled offer stays pinned to its VC until it is taken.
        hold_reg    <= 1'b1;
        hold_vc_reg <= grant;
      end
    end
  end

  a_in_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.in_valid));

endmodule

// File: tb/tb_noc_vc_buffer.sv
// Directed bench for noc_vc_buffer: FIFO order, write-through latency, fill limits,
// packet locking, round-robin fairness, stall hold and asynchronous reset.
module tb_noc_vc_buffer;
  localparam int FW = 32;
  localparam int CH = 2;
  localparam int DP = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_vc_buffer_if #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DP)) bus ();
  noc_vc_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] fc(input int v);
    return bus.fill_count[v*CW +: CW];
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int vc, input logic [31:0] d, input logic l);
    bus.in_valid = 2'(1) << vc;
    bus.in_flit  = d;
    bus.in_last  = l;
    cycle();
    bus.in_valid = '0;
    $display("push vc%0d data=%08h last=%0b", vc, d, l);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] vc, input logic [31:0] d, input logic l);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_vc"},    64'(bus.out_vc),    64'(vc));
    check({tag, "_flit"},  64'(bus.out_flit),  64'(d));
    check({tag, "_last"},  64'(bus.out_last),  64'(l));
    $display("offer %s vc=%02b data=%08h last=%0b", tag, bus.out_vc, bus.out_flit, bus.out_last);
  endtask

  initial begin
    logic [31:0] d;
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid),  64'(0));
    check("rst_out_vc",    64'(bus.out_vc),     64'(0));
    check("rst_fill",      64'(bus.fill_count), 64'(0));
    check("rst_in_ready",  64'(bus.in_ready),   64'(2'b11));
    rst_n = 1'b1;
    cycle();

    // 1: single flit, one-cycle latency
    push(0, 32'hA5, 1'b1);
    expect_out("t1", 2'b01, 32'hA5, 1'b1);
    check("t1_fill0", 64'(fc(0)), 64'(1));
    bus.out_ready = 1'b1;
    cycle();
    check("t1_fill0_after", 64'(fc(0)),         64'(0));
    check("t1_idle",        64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    // 2: fill VC1 to DEPTH+1, blocked write, read+write across pointer wrap
    for (int i = 0; i < 9; i++) begin
      d = 32'h100 + 32'(i);
      push(1, d, 1'b1);
      q.push_back(d);
      if (i == 7) check("t2_ready_at8", 64'(bus.in_ready[1]), 64'(1));
    end
    check("t2_in_ready_full", 64'(bus.in_ready), 64'(2'b01));
    check("t2_fill1_full",    64'(fc(1)),        64'(9));
    bus.in_valid = 2'b10;
    bus.in_flit  = 32'hDEAD;
    bus.in_last  = 1'b1;
    cycle();
    bus.in_valid = '0;
    check("t2_fill1_blocked", 64'(fc(1)),        64'(9));
    check("t2_head_stable",   64'(bus.out_flit), 64'(q[0]));
    bus.out_ready = 1'b1;
    cycle();
    void'(q.pop_front());
    bus.out_ready = 1'b0;
    check("t2_fill1_8", 64'(fc(1)), 64'(8));
    for (int j = 0; j < 10; j++) begin
      check("t2_rw_flit", 64'(bus.out_flit), 64'(q[0]));
      check("t2_rw_vc",   64'(bus.out_vc),   64'(2'b10));
      d = 32'h109 + 32'(j);
      bus.in_valid  = 2'b10;
      bus.in_flit   = d;
      bus.in_last   = 1'b1;
      bus.out_ready = 1'b1;
      cycle();
      void'(q.pop_front());
      q.push_back(d);
      check("t2_rw_fill", 64'(fc(1)), 64'(8));
      $display("rw vc1 wrote=%08h", d);
    end
    bus.in_valid = '0;
    for (int j = 0; j < 8; j++) begin
      check("t2_drain_flit", 64'(bus.out_flit), 64'(q[0]));
      cycle();
      void'(q.pop_front());
    end
    check("t2_fill1_empty", 64'(fc(1)),         64'(0));
    check("t2_idle",        64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    // 3: packet lock blocks VC1 while VC0's packet is incomplete
    push(0, 32'h300, 1'b0);
    expect_out("t3_f0", 2'b01, 32'h300, 1'b0);
    bus.out_ready = 1'b1;
    cycle();
    check("t3_locked_empty", 64'(bus.out_valid), 64'(0));
    push(1, 32'h310, 1'b1);
    check("t3_no_interleave", 64'(bus.out_valid), 64'(0));
    check("t3_fill1",         64'(fc(1)),         64'(1));
    cycle();
    check("t3_still_locked",  64'(bus.out_valid), 64'(0));
    push(0, 32'h301, 1'b0);
    expect_out("t3_f1", 2'b01, 32'h301, 1'b0);
    push(0, 32'h302, 1'b1);
    expect_out("t3_f2", 2'b01, 32'h302, 1'b1);
    cycle();
    expect_out("t3_vc1", 2'b10, 32'h310, 1'b1);
    cycle();
    check("t3_idle", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    // 4: round-robin alternation of single-flit packets
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h400 + 32'(i), 1'b1);
      push(1, 32'h410 + 32'(i), 1'b1);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) expect_out("t4_vc0", 2'b01, 32'h400 + 32'(i / 2), 1'b1);
      else            expect_out("t4_vc1", 2'b10, 32'h410 + 32'(i / 2), 1'b1);
      cycle();
    end
    check("t4_idle", 64'(bus.out_valid), 64'(0));

    // 5: stalled offer on VC0 stays put even though round-robin now favours VC1
    push(0, 32'h4FF, 1'b1);
    cycle();
    check("t5_setup_idle", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;
    push(0, 32'h500, 1'b1);
    expect_out("t5_offer", 2'b01, 32'h500, 1'b1);
    push(1, 32'h510, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_flit", 64'(bus.out_flit), 64'(32'h500));
      check("t5_hold_vc",   64'(bus.out_vc),   64'(2'b01));
      if (i < 4) cycle();
    end
    bus.out_ready = 1'b1;
    cycle();
    expect_out("t5_vc1", 2'b10, 32'h510, 1'b1);
    cycle();
    check("t5_idle", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    // 6: asynchronous reset mid-packet
    push(0, 32'h600, 1'b0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    push(0, 32'h601, 1'b0);
    push(0, 32'h602, 1'b0);
    push(0, 32'h603, 1'b0);
    push(1, 32'h610, 1'b1);
    check("t6_fill0", 64'(fc(0)), 64'(3));
    check("t6_fill1", 64'(fc(1)), 64'(1));
    expect_out("t6_locked", 2'b01, 32'h601, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid",    64'(bus.out_valid),  64'(0));
    check("t6_rst_vc",       64'(bus.out_vc),     64'(0));
    check("t6_rst_fill",     64'(bus.fill_count), 64'(0));
    check("t6_rst_in_ready", 64'(bus.in_ready),   64'(2'b11));
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    push(1, 32'h620, 1'b1);
    expect_out("t6_after", 2'b10, 32'h620, 1'b1);
    bus.out_ready = 1'b1;
    cycle();
    check("t6_fill1_after", 64'(fc(1)),         64'(0));
    check("t6_idle",        64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
